// File: rtl/stream_xbar.sv
// stream_xbar: packet-locking stream crossbar. Each sink port has its own
// round-robin arbiter that holds its grant for a whole packet, and a
// registered output slice that sustains one beat per cycle.
module stream_xbar #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 4,
    parameter int M_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
    input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_o,
    output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
    output logic [M_DATA_COUNT-1:0]              m_last_o,
    output logic [M_DATA_COUNT-1:0]              m_valid_o,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i
);
    localparam int DW = T_DATA_WIDTH;
    localparam int S  = S_DATA_COUNT;
    localparam int M  = M_DATA_COUNT;
    localparam int IW = T_ID___WIDTH;
    localparam int TW = T_DEST_WIDTH;

    typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

    state_t          state_q [M];
    state_t          state_d [M];
    logic [IW-1:0]   ptr_q   [M];
    logic [IW-1:0]   ptr_d   [M];
    logic [IW-1:0]   gnt_q   [M];
    logic [IW-1:0]   gnt_d   [M];
    logic [DW-1:0]   data_q  [M];
    logic [DW-1:0]   data_d  [M];
    logic [IW-1:0]   id_q    [M];
    logic [IW-1:0]   id_d    [M];
    logic [M-1:0]    last_q, last_d;
    logic [M-1:0]    valid_q, valid_d;
    logic [S-1:0]    grant_rdy;
    logic [S-1:0]    drop;

    // A source aimed at a non-existent sink is drained so it cannot stall.
    always_comb begin
        for (int i = 0; i < S; i++) begin
            drop[i] = !rst && (int'(s_dest_i[i*TW +: TW]) >= M);
        end
    end

    // Per-output arbitration, packet lock and output slice next-state.
    always_comb begin
        int     idx;
        int     g;
        logic   can_load;
        logic   load;
        logic   found;
        grant_rdy = '0;
        last_d    = last_q;
        valid_d   = valid_q;
        for (int k = 0; k < M; k++) begin
            state_d[k] = state_q[k];
            ptr_d[k]   = ptr_q[k];
            gnt_d[k]   = gnt_q[k];
            data_d[k]  = data_q[k];
            id_d[k]    = id_q[k];
            can_load   = !valid_q[k] || m_ready_i[k];
            load       = 1'b0;
            found      = 1'b0;
            idx        = 0;
            g          = int'(gnt_q[k]);
            case (state_q[k])
                ST_IDLE: begin
                    // Scan upward from the pointer; the first hit wins.
                    for (int j = 0; j < S; j++) begin
                        idx = int'(ptr_q[k]) + j;
                        if (idx >= S) begin
                            idx = idx - S;
                        end
                        if (!found && s_valid_i[idx] && (int'(s_dest_i[idx*TW +: TW]) == k)) begin
                            found    = 1'b1;
                            gnt_d[k] = IW'(idx);
                        end
                    end
                    if (found) begin
                        state_d[k] = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    grant_rdy[g] = grant_rdy[g] | can_load;
                    if (can_load && s_valid_i[g]) begin
                        load      = 1'b1;
                        data_d[k] = s_data_i[g*DW +: DW];
                        id_d[k]   = gnt_q[k];
                        last_d[k] = s_last_i[g];
                        if (s_last_i[g]) begin
                            state_d[k] = ST_IDLE;
                            ptr_d[k]   = (g == S - 1) ? '0 : IW'(g + 1);
                        end
                    end
                end
                default: state_d[k] = ST_IDLE;
            endcase
            if (load) begin
                valid_d[k] = 1'b1;
            end else if (m_ready_i[k]) begin
                valid_d[k] = 1'b0;
            end
        end
    end

    // Arbiter state and output slice registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < M; k++) begin
                state_q[k] <= ST_IDLE;
                ptr_q[k]   <= '0;
                gnt_q[k]   <= '0;
                data_q[k]  <= '0;
                id_q[k]    <= '0;
            end
            last_q  <= '0;
            valid_q <= '0;
        end else begin
            for (int k = 0; k < M; k++) begin
                state_q[k] <= state_d[k];
                ptr_q[k]   <= ptr_d[k];
                gnt_q[k]   <= gnt_d[k];
                data_q[k]  <= data_d[k];
                id_q[k]    <= id_d[k];
            end
            last_q  <= last_d;
            valid_q <= valid_d;
        end
    end

    for (genvar k = 0; k < M; k++) begin : g_out
        assign m_data_o[k*DW +: DW] = data_q[k];
        assign m_id_o[k*IW +: IW]   = id_q[k];
    end

    assign m_last_o  = last_q;
    assign m_valid_o = valid_q;
    assign s_ready_o = (grant_rdy & {S{!rst}}) | drop;

endmodule

// File: tb/tb_stream_xbar.sv
// Bench for stream_xbar: table of idle/drop ready vectors, directed
// sequences for timing corners, and a randomized run against a
// per-(sink, source) ordering and packet-lock reference model.
module tb_stream_xbar;
    localparam int DW = 8, S = 4, M = 3, IDW = 2, TDW = 2;

    logic clk = 1'b0;
    logic rst;
    logic [DW*S-1:0]  s_data;
    logic [TDW*S-1:0] s_dest;
    logic [S-1:0]     s_last, s_valid, s_ready;
    logic [DW*M-1:0]  m_data;
    logic [IDW*M-1:0] m_id;
    logic [M-1:0]     m_last, m_valid, m_ready;

    stream_xbar #(.T_DATA_WIDTH(DW), .S_DATA_COUNT(S), .M_DATA_COUNT(M),
                  .T_ID___WIDTH(IDW), .T_DEST_WIDTH(TDW)) dut (
        .clk(clk), .rst(rst),
        .s_data_i(s_data), .s_dest_i(s_dest), .s_last_i(s_last),
        .s_valid_i(s_valid), .s_ready_o(s_ready),
        .m_data_o(m_data), .m_id_o(m_id), .m_last_o(m_last),
        .m_valid_o(m_valid), .m_ready_i(m_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] dest;
        logic [7:0] data;
        logic       last;
        int         gap;
    } beat_t;

    typedef struct packed {
        logic [1:0] dest;
        logic [1:0] src;
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct packed {
        logic [1:0]  k;
        logic [1:0]  id;
        logic [7:0]  data;
        logic        last;
        logic [31:0] cyc;
    } ent_t;

    typedef struct {
        logic [1:0]   dest;
        logic         valid;
        logic [S-1:0] exp_ready;
        logic [M-1:0] exp_mvalid;
    } vec_t;

    beat_t src_q [S][$];
    exp_t  exp_q [$];
    ent_t  log_q [$];
    int    n_checks = 0;
    int    n_err = 0;
    int    cyc = 0;
    bit    drv_en = 1'b1;
    bit    rand_ready = 1'b0;
    bit    log_en = 1'b1;
    logic [S-1:0]   acc;
    logic [M-1:0]   in_pkt;
    logic [IDW-1:0] cur_id [M];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic ent_t mk_ent(int k, int id, int data, int last, int c);
        ent_t e;
        e.k = 2'(k); e.id = 2'(id); e.data = 8'(data); e.last = 1'(last); e.cyc = 32'(c);
        return e;
    endfunction

    // Source driver: presents the head beat of each source queue.
    initial begin
        s_valid = '0; s_data = '0; s_dest = '0; s_last = '0;
        forever begin
            @(posedge clk); #1;
            if (rand_ready) m_ready = M'($urandom_range(0, (1 << M) - 1));
            if (drv_en) begin
                for (int i = 0; i < S; i++) begin
                    if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                    s_valid[i] = 1'b0;
                    if (src_q[i].size() > 0) begin
                        if (src_q[i][0].gap > 0) begin
                            beat_t b;
                            b = src_q[i][0];
                            b.gap = b.gap - 1;
                            src_q[i][0] = b;
                        end else begin
                            s_valid[i]             = 1'b1;
                            s_data[i*DW +: DW]     = src_q[i][0].data;
                            s_dest[i*TDW +: TDW]   = src_q[i][0].dest;
                            s_last[i]              = src_q[i][0].last;
                        end
                    end
                end
            end
        end
    end

    // Monitor and reference model: every emitted beat must be the oldest
    // outstanding beat that its source sent to that sink, and a sink never
    // interleaves sources inside a packet.
    initial begin
        acc = '0; in_pkt = '0;
        for (int k = 0; k < M; k++) cur_id[k] = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                acc = '0; in_pkt = '0;
                exp_q.delete();
            end else begin
                for (int i = 0; i < S; i++) begin
                    acc[i] = s_valid[i] & s_ready[i];
                    if (acc[i] && int'(s_dest[i*TDW +: TDW]) < M) begin
                        exp_t x;
                        x.dest = s_dest[i*TDW +: TDW]; x.src = 2'(i);
                        x.data = s_data[i*DW +: DW];   x.last = s_last[i];
                        exp_q.push_back(x);
                    end
                end
                for (int k = 0; k < M; k++) begin
                    if (m_valid[k] && m_ready[k]) begin
                        logic [IDW-1:0] id;
                        logic [7:0]     d;
                        logic           l;
                        int             found;
                        id = m_id[k*IDW +: IDW]; d = m_data[k*DW +: DW]; l = m_last[k];
                        if (log_en) log_q.push_back(mk_ent(k, int'(id), int'(d), int'(l), cyc));
                        if (in_pkt[k]) check("packet_lock_id", 64'(id), 64'(cur_id[k]));
                        found = -1;
                        for (int j = 0; j < exp_q.size(); j++)
                            if (found < 0 && exp_q[j].dest == 2'(k) && exp_q[j].src == id) found = j;
                        check("beat_expected", 64'(found >= 0), 64'(1));
                        if (found >= 0) begin
                            check("beat_data_last", {55'(0), d, l}, {55'(0), exp_q[found].data, exp_q[found].last});
                            exp_q.delete(found);
                        end
                        in_pkt[k] = !l;
                        cur_id[k] = id;
                    end
                end
            end
        end
    end

    task automatic tick_drv(); @(posedge clk); #2; endtask
    task automatic tick_chk(); @(negedge clk); #1; endtask

    task automatic do_reset();
        tick_drv();
        rst = 1'b1;
        for (int i = 0; i < S; i++) src_q[i].delete();
        repeat (2) tick_drv();
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic push_pkt(int src, int dest, int len, int base, int gap_at, int gap_len);
        for (int b = 0; b < len; b++) begin
            beat_t x;
            x.dest = 2'(dest); x.data = 8'(base + b); x.last = (b == len - 1);
            x.gap  = (b == gap_at) ? gap_len : 0;
            src_q[src].push_back(x);
        end
    endtask

    task automatic wait_log(input string nm, int n, int budget);
        int w = 0;
        while (log_q.size() < n && w < budget) begin tick_chk(); w++; end
        check(nm, 64'(log_q.size() >= n), 64'(1));
    endtask

    function automatic ent_t log_at(int j);
        ent_t z = '0;
        return (j < log_q.size()) ? log_q[j] : z;
    endfunction

    task automatic check_zero_outputs(input string nm);
        check({nm, "_m_valid"}, 64'(m_valid), 64'(0));
        check({nm, "_m_last"},  64'(m_last),  64'(0));
        check({nm, "_m_data"},  64'(m_data),  64'(0));
        check({nm, "_m_id"},    64'(m_id),    64'(0));
        check({nm, "_s_ready"}, 64'(s_ready), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl [6];
        int   t, w;
        bit   busy;
        rst = 1'b1; m_ready = '1;

        // Reset state
        repeat (2) tick_drv();
        tick_chk();
        check_zero_outputs("reset");
        rst = 1'b0;

        // Table: idle ready vectors, including the drop path
        tbl[0] = '{2'd0, 1'b1, 4'b0000, 3'b000};
        tbl[1] = '{2'd1, 1'b0, 4'b0000, 3'b000};
        tbl[2] = '{2'd2, 1'b1, 4'b0000, 3'b000};
        tbl[3] = '{2'd3, 1'b1, 4'b0001, 3'b000};
        tbl[4] = '{2'd3, 1'b0, 4'b0001, 3'b000};
        tbl[5] = '{2'd2, 1'b0, 4'b0000, 3'b000};
        drv_en = 1'b0;
        for (int r = 0; r < 6; r++) begin
            tick_chk();
            s_dest[1:0] = tbl[r].dest;
            s_valid[0]  = tbl[r].valid;
            #1;
            check($sformatf("tbl%0d_s_ready", r), 64'(s_ready), 64'(tbl[r].exp_ready));
            check($sformatf("tbl%0d_m_valid", r), 64'(m_valid), 64'(tbl[r].exp_mvalid));
            s_valid[0] = 1'b0;
        end
        s_dest[1:0] = 2'd0;
        drv_en = 1'b1;

        // Single path: source 0 -> sink 1, three beats
        do_reset();
        push_pkt(0, 1, 3, 8'hA1, -1, 0);
        t = cyc + 1;
        wait_log("single_wait", 3, 20);
        repeat (3) tick_chk();
        check("single_count", 64'(log_q.size()), 64'(3));
        for (int j = 0; j < 3; j++)
            check($sformatf("single_beat%0d", j), 64'(log_at(j)), 64'(mk_ent(1, 0, 8'hA1 + j, j == 2, t + 2 + j)));

        // Round robin on sink 0 with two 2-beat packets per source
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < 3; s++) push_pkt(s, 0, 2, s * 16 + r * 2, -1, 0);
        t = cyc + 1;
        wait_log("rr_wait", 12, 100);
        for (int n = 0; n < 12; n++) begin
            int r, s, b;
            r = n / 6; s = (n / 2) % 3; b = n % 2;
            check($sformatf("rr_beat%0d", n), 64'(log_at(n)),
                  64'(mk_ent(0, s, s * 16 + r * 2 + b, b, t + 2 + (n / 2) * 3 + b)));
        end

        // Packet lock across a valid gap while a competitor waits
        do_reset();
        push_pkt(1, 2, 4, 8'h10, 2, 2);
        push_pkt(3, 2, 2, 8'h30, -1, 0);
        wait_log("lock_wait", 6, 60);
        for (int n = 0; n < 6; n++) begin
            int eid, ed;
            eid = (n < 4) ? 1 : 3;
            ed  = (n < 4) ? 8'h10 + n : 8'h30 + n - 4;
            check($sformatf("lock_beat%0d", n), 64'({log_at(n).id, log_at(n).data}), 64'({2'(eid), 8'(ed)}));
        end

        // Backpressure on sink 0 for five cycles mid-packet
        do_reset();
        push_pkt(0, 0, 8, 8'h40, -1, 0);
        wait_log("bp_wait_a", 3, 20);
        tick_drv();
        m_ready[0] = 1'b0;
        for (int h = 0; h < 5; h++) begin
            tick_chk();
            check($sformatf("bp_hold_valid%0d", h), 64'(m_valid[0]), 64'(1));
            check($sformatf("bp_hold_data%0d", h),  64'(m_data[7:0]), 64'(8'h43));
            check($sformatf("bp_hold_sready%0d", h), 64'(s_ready[0]), 64'(0));
        end
        tick_drv();
        m_ready[0] = 1'b1;
        wait_log("bp_wait_b", 8, 30);
        repeat (3) tick_chk();
        check("bp_count", 64'(log_q.size()), 64'(8));
        for (int j = 0; j < 8; j++)
            check($sformatf("bp_data%0d", j), 64'(log_at(j).data), 64'(8'h40 + j));
        check("bp_resume_rate", 64'(log_at(7).cyc - log_at(3).cyc), 64'(4));

        // Parallel streams plus a dropped packet
        do_reset();
        push_pkt(0, 0, 4, 8'h50, -1, 0);
        push_pkt(1, 1, 4, 8'h60, -1, 0);
        push_pkt(2, 3, 3, 8'h70, -1, 0);
        t = cyc + 1;
        tick_drv();
        tick_chk();
        check("drop_ready", 64'(s_ready[2]), 64'(1));
        check("idle_cycle_ready", 64'(s_ready[0]), 64'(0));
        wait_log("par_wait", 8, 30);
        repeat (3) tick_chk();
        check("par_count", 64'(log_q.size()), 64'(8));
        for (int n = 0; n < 8; n++) begin
            int k;
            k = n % 2;
            check($sformatf("par_beat%0d", n), 64'(log_at(n)),
                  64'(mk_ent(k, k, 8'h50 + k * 16 + n / 2, (n / 2) == 3, t + 2 + n / 2)));
        end
        check("drop_drained", 64'(src_q[2].size()), 64'(0));

        // Reset mid-packet clears slices, grants and pointers
        do_reset();
        push_pkt(2, 0, 1, 8'h80, -1, 0);
        push_pkt(0, 0, 4, 8'h90, -1, 0);
        wait_log("rmp_wait_a", 3, 30);
        tick_drv();
        rst = 1'b1;
        for (int i = 0; i < S; i++) src_q[i].delete();
        tick_drv();
        rst = 1'b0;
        tick_chk();
        check_zero_outputs("rmp");
        log_q.delete();
        push_pkt(3, 0, 2, 8'hB0, -1, 0);
        push_pkt(2, 0, 2, 8'hA0, -1, 0);
        wait_log("rmp_wait_b", 4, 30);
        for (int n = 0; n < 4; n++)
            check($sformatf("rmp_id%0d", n), 64'(log_at(n).id), 64'((n < 2) ? 2 : 3));

        // Randomized traffic against the reference model
        do_reset();
        log_en = 1'b0;
        rand_ready = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick_drv();
            for (int i = 0; i < S; i++)
                if (src_q[i].size() == 0 && $urandom_range(0, 3) == 0)
                    push_pkt(i, $urandom_range(0, 3), $urandom_range(1, 4), $urandom_range(0, 255),
                             $urandom_range(0, 4), $urandom_range(0, 2));
        end
        tick_drv();
        rand_ready = 1'b0;
        m_ready = '1;
        w = 0;
        busy = 1'b1;
        while (busy && w < 300) begin
            tick_chk();
            w++;
            busy = (exp_q.size() > 0) || (m_valid != '0);
            for (int i = 0; i < S; i++) if (src_q[i].size() > 0) busy = 1'b1;
        end
        check("random_drained", 64'(exp_q.size()), 64'(0));
        check("random_idle", 64'(busy), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/stream_xbar.md
# stream_xbar

Registered, packet-locking streaming crossbar that routes S_DATA_COUNT source streams to M_DATA_COUNT sink streams by per-beat destination field. It replaces the combinational schedule/crossbar pair with per-output round-robin arbitration, grants held for a whole packet (through `last`), and a registered output slice on every master port. It sits between stream producers and consumers in the same fabric position as the existing crossbar.

## Interface
- T_DATA_WIDTH, 8, data bits per beat
- S_DATA_COUNT, 4, number of source (slave) ports, ≥2
- M_DATA_COUNT, 3, number of sink (master) ports, ≥2; need not be a power of two
- T_ID___WIDTH, $clog2(S_DATA_COUNT), source-index width on m_id_o
- T_DEST_WIDTH, $clog2(M_DATA_COUNT), destination field width
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- s_data_i  in  T_DATA_WIDTH*S_DATA_COUNT  source data, port i at slice i
- s_dest_i  in  T_DEST_WIDTH*S_DATA_COUNT  destination index; stable for a whole packet
- s_last_i  in  S_DATA_COUNT  last beat of packet
- s_valid_i  in  S_DATA_COUNT  source beat valid
- s_ready_o  out  S_DATA_COUNT  source beat accepted when valid&ready
- m_data_o  out  T_DATA_WIDTH*M_DATA_COUNT  sink data
- m_id_o  out  T_ID___WIDTH*M_DATA_COUNT  index of source that produced the beat
- m_last_o  out  M_DATA_COUNT  last beat of packet
- m_valid_o  out  M_DATA_COUNT  sink beat valid
- m_ready_i  in  M_DATA_COUNT  sink accepts beat

## Operation
- Request: source i requests output k when s_valid_i[i] and s_dest_i[i]==k.
- Per output k, a two-state FSM: IDLE, BUSY; plus round-robin pointer ptr_k (T_ID___WIDTH bits) and grant register gnt_k.
- IDLE: if any requester, gnt_k ← first requester at index ≥ ptr_k scanning upward, wrapping modulo S_DATA_COUNT; → BUSY. No beat is accepted in the IDLE cycle.
- BUSY: s_ready_o[gnt_k] = out-slice k can load (!m_valid_o[k] | m_ready_i[k]). An accepted beat loads slice k with data, last, id=gnt_k.
- BUSY exit: accepted beat with s_last_i → IDLE, ptr_k ← (gnt_k+1) mod S_DATA_COUNT (wraps S-1 → 0).
- Grant is held while the granted source deasserts valid mid-packet; other sources wait.
- Each source has a single dest at a time, so it is granted by at most one output; s_ready_o[i] is the OR over outputs granting i.
- Out-of-range dest (s_dest_i ≥ M_DATA_COUNT): packet is dropped: s_ready_o[i]=1, beats discarded through and including the last beat; nothing is emitted.
- Output slice k: m_valid_o[k] set on load, cleared when m_ready_i[k] and no new load; load and drain in the same cycle keep valid=1 (full throughput).
- Output data and id are held stable while m_valid_o & !m_ready_i.

## Timing
- Reset values (apply while rst=1, on the next edge): m_valid_o=0, m_last_o=0, m_data_o=0, m_id_o=0, all FSMs IDLE, all ptr=0, s_ready_o=0 (except the drop path, which is inactive during reset).
- First beat of a packet: s_valid at cycle t → arbitration at edge t → s_ready at t+1 → m_valid at t+2.
- Later beats: 1 beat/cycle; beat accepted at t appears on m_* at t+1.
- Packet-to-packet gap on one output: 1 idle cycle (IDLE arbitration).
- Backpressure: m_ready_i low holds the slice; s_ready_o for the granted source falls in the same cycle (combinational).
- Reset mid-packet: in-flight beats in the slices are lost and grants are cleared; sources must restart packets.

## Test plan
- Single path: source 0, dest 1, 3-beat packet 0xA1,0xA2,0xA3(last), m_ready=1 → m_data_o[1] shows A1,A2,A3 at t+2..t+4, m_id=0, m_last on A3 only; output 0 stays idle.
- Round robin: sources 0,1,2 each send continuous 2-beat packets to dest 0 → m_id sequence 0,0,1,1,2,2,0,0…; ptr wraps 2→0.
- Packet lock: source 1 sends a 4-beat packet to dest 2 with a valid gap at beat 2 while source 3 is requesting dest 2 → all 4 beats from id 1 are emitted contiguously before any from id 3.
- Backpressure: m_ready_i[0] low for 5 cycles mid-packet → m_data/m_id held, s_ready of the granted source low, no beats lost or duplicated; throughput 1/cycle resumes.
- Parallel and drop: source 0→dest 0 and source 1→dest 1 concurrently → both stream at full rate; source 2 with dest 3 (M=3) → s_ready=1, all beats discarded, no m_valid.
- Reset mid-packet: assert rst for 1 cycle during beat 2 → all outputs 0 next cycle, new packet from source 2 is granted first (ptr=0 scan).
